// File: rtl/call_stack_unit.sv
// call_stack_unit: parametrised call/return stack supplying the return PC.
// Full policy: WRAP_MODE=0 drops the push, WRAP_MODE=1 overwrites the oldest entry.
// Optional build macro CALL_STACK_PEEK_EN adds the peek_idx/peek_data/peek_valid read port.
module call_stack_unit #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WRAP_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       clr_flags,
`ifdef CALL_STACK_PEEK_EN
    input  logic [$clog2(DEPTH)-1:0]   peek_idx,
    output logic [DATA_W-1:0]          peek_data,
    output logic                       peek_valid,
`endif
    output logic [DATA_W-1:0]          top_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;   // next free slot; top entry sits just below
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  ptr_inc;
    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic              ovf_evt;
    logic              unf_evt;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign overflow = overflow_q;
    assign underflow = underflow_q;

    // Pointer arithmetic modulo DEPTH (DEPTH need not be a power of two).
    always_comb begin
        top_idx = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - 1'b1;
        ptr_inc = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end

    // Combinational top-of-stack read; reads as zero when empty.
    always_comb begin
        top_data = '0;
        if (!empty) begin
            top_data = mem_q[top_idx];
        end
    end

    // Operation decode: storage write, pointer/count next state and flag events.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        we       = 1'b0;
        waddr    = wr_ptr_q;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        if (push && pop && !empty) begin
            // return-then-call: replace the top entry in place
            we    = 1'b1;
            waddr = top_idx;
        end else if (push) begin
            unf_evt = pop;
            if (!full) begin
                we       = 1'b1;
                wr_ptr_d = ptr_inc;
                count_d  = count_q + 1'b1;
            end else begin
                ovf_evt = 1'b1;
                if (WRAP_MODE != 0) begin
                    // when full, the next free slot is the oldest entry
                    we       = 1'b1;
                    wr_ptr_d = ptr_inc;
                end
            end
        end else if (pop) begin
            if (empty) begin
                unf_evt = 1'b1;
            end else begin
                wr_ptr_d = top_idx;
                count_d  = count_q - 1'b1;
            end
        end
        overflow_d  = (overflow_q  & ~clr_flags) | ovf_evt;
        underflow_d = (underflow_q & ~clr_flags) | unf_evt;
    end

    // Control state: pointer, occupancy and sticky flags; reset empties the stack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= push_data;
        end
    end

`ifdef CALL_STACK_PEEK_EN
    logic [PTR_W-1:0] peek_pos;

    // Peek read: entry peek_idx below the top, zero when beyond occupancy.
    always_comb begin
        if ({1'b0, peek_idx} <= {1'b0, top_idx}) begin
            peek_pos = top_idx - peek_idx;
        end else begin
            peek_pos = PTR_W'({1'b0, top_idx} + (PTR_W+1)'(DEPTH) - {1'b0, peek_idx});
        end
        peek_valid = (CNT_W'(peek_idx) < count_q);
        peek_data  = '0;
        if (peek_valid) begin
            peek_data = mem_q[peek_pos];
        end
    end
`endif

endmodule
